// File: rtl/kmeans_sched_pkg.sv
// Shared types and defaults for the Kmeans APB scheduler.
//   sched_state_t : transfer FSM states (IDLE -> SETUP -> ACCESS -> RESP)
//   apb_req_t     : one request record at the default register-slave widths
//   onehot2       : index -> 2-bit one-hot helper
package kmeans_sched_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 91;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } sched_state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } apb_req_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   req        : pending requests, index = requester
//   last_grant : index of the requester served most recently
//   en         : arbitration allowed this cycle
//   gnt        : one-hot grant (zero when disabled or nothing pending)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Contention: whoever was not served last goes first.
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/kmeans_apb_sched.sv
// APB master scheduler in front of the Kmeans accelerator register slave.
// Two requesters (r0 = host config, r1 = result readout) share one APB port.
//   clk, rst                  : clock, asynchronous active-high reset
//   req_valid/ready/write     : per-requester handshake and direction
//   req_addr/req_wdata        : per-requester address and write data
//   rsp_valid/rsp_rdata/err   : one-cycle response pulse, held data and timeout flag
//   busy                      : transfer in progress
//   psel/penable/pwrite/paddr/pwdata/prdata/pready : APB master side
//   interupt/irq_clr/irq_pending : rising-edge sticky interrupt flag
module kmeans_apb_sched
  import kmeans_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_W_DEF,
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_write,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_WIDTH-1:0]      paddr,
  output logic [DATA_WIDTH-1:0]      pwdata,
  input  logic [DATA_WIDTH-1:0]      prdata,
  input  logic                       pready,
  input  logic                       interupt,
  input  logic                       irq_clr,
  output logic                       irq_pending
);

  sched_state_t state_q, state_d;

  logic [1:0]            gnt;
  logic                  accept;
  logic                  timeout;
  logic                  g_q, last_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [TO_WIDTH-1:0]   cnt_q;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  busy_q, busy_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  irq_prev_q, irq_q, irq_d;

  // Grant is gated by rst so req_ready reads 0 while reset is held.
  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .en         ((state_q == S_IDLE) && !rst),
    .gnt        (gnt)
  );

  assign accept  = |gnt;
  // cnt_q counts completed pready-less ACCESS cycles; this is the last allowed one.
  assign timeout = (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready || timeout) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: computed from the next state so every output is a flop.
  always_comb begin
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP) ? onehot2(g_q) : 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if ((state_q == S_ACCESS) && (state_d == S_RESP)) begin
      // pready wins over a coincident timeout.
      rsp_err_d   = !pready;
      rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
    end
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if (interupt && !irq_prev_q) irq_d = 1'b1;
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      g_q         <= 1'b0;
      last_q      <= 1'b1;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      irq_prev_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      irq_prev_q  <= interupt;
      irq_q       <= irq_d;
      if (accept) begin
        g_q      <= gnt[1];
        pwrite_q <= req_write[gnt[1]];
        paddr_q  <= req_addr[gnt[1]];
        pwdata_q <= req_wdata[gnt[1]];
      end
      if (state_q == S_SETUP) begin
        cnt_q <= '0;
      end else if ((state_q == S_ACCESS) && !pready) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_RESP) last_q <= g_q;
    end
  end

  assign req_ready   = gnt;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign irq_pending = irq_q;

endmodule
